sd_port_arbiter: RTL
====================

SD_PORT_ARBITER -- requirements
Module: sd_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, max cycles a grant may see sd_ready low before abort.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles between grant release and next grant.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req0 / gnt0  in / out  1 / 1  writer request, held for whole transaction / writer grant.
REQ-006 wr0, addr0, din0  in  1, 32, 8  writer command strobe, byte address, write data.
REQ-007 ready0, rfnb0  out  1, 1  writer view of sd_ready, sd_ready_for_next_byte.
REQ-008 req1 / gnt1  in / out  1 / 1  reader request / reader grant.
REQ-009 rd1, addr1  in  1, 32  reader command strobe, byte address.
REQ-010 ready1, dout1, bavail1  out  1, 8, 1  reader view of sd_ready, sd_dout, sd_byte_available.
REQ-011 sd_rd, sd_wr, sd_address, sd_din  out  1, 1, 32, 8  to SD controller.
REQ-012 sd_ready, sd_dout, sd_byte_available, sd_ready_for_next_byte  in  1, 8, 1, 1  from SD controller.
REQ-013 timeout_err  out  1  sticky; set on watchdog abort, cleared by reset or next grant.

Function
REQ-014 States SHALL be IDLE, GNT_W, GNT_R, GAP.
REQ-015 IDLE: grant SHALL be issued only when sd_ready=1; gnt asserted the cycle after the decision (1-cycle latency).
REQ-016 Simultaneous req0 and req1 in IDLE SHALL be resolved round-robin: requester not granted last wins; after reset writer has priority.
REQ-017 Single request in IDLE SHALL be granted regardless of round-robin pointer.
REQ-018 GNT_W: sd_wr=wr0, sd_address=addr0, sd_din=din0, sd_rd=0; ready0=sd_ready, rfnb0=sd_ready_for_next_byte.
REQ-019 GNT_R: sd_rd=rd1, sd_address=addr1, sd_din=0, sd_wr=0; ready1=sd_ready, dout1=sd_dout, bavail1=sd_byte_available.
REQ-020 Non-granted requester SHALL see ready=0, rfnb0=0, bavail1=0, dout1=0; its rd/wr ignored.
REQ-021 IDLE/GAP: sd_rd=0, sd_wr=0, sd_address holds last driven value, sd_din=0.
REQ-022 Grant SHALL be released when req of owner drops; transition to GAP, gnt deasserted same edge.
REQ-023 req drop while sd_ready=0 SHALL still release; GAP SHALL then extend until sd_ready=1 and GAP_CYCLES elapsed.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles when sd_ready=1, then go IDLE; pointer updated on entry to GAP.
REQ-025 Watchdog counter SHALL count cycles in GNT_W/GNT_R with sd_ready=0, clear when sd_ready=1.
REQ-026 Counter reaching TIMEOUT_CYCLES-1 SHALL force GAP, deassert gnt, set timeout_err; counter saturates, never wraps.
REQ-027 Owner keeping req high after watchdog abort SHALL not be re-granted until req dropped once (per-requester lockout flag).
REQ-028 Command strobes SHALL be muxed combinationally from granted port; grant/state/pointer/counter registered.

Reset
REQ-029 Reset SHALL force IDLE, gnt0=gnt1=0, pointer=writer, counter=0, lockouts=0, timeout_err=0, sd_address=0, all strobes 0.
REQ-030 Reset mid-transaction SHALL drop grant on the same edge; no strobe asserted the following cycle.

Structure
REQ-031 State encoding, requester IDs and SD port widths (32-bit address, 8-bit data) SHALL live in shared package sd_pkg.
REQ-032 Watchdog SHALL be sub-module sd_watchdog (count, clear, saturate, expire output); rest flat.

Verification
REQ-033 req0=1 only, sd_ready=1 -> gnt0=1 one cycle later; wr0 pulse appears on sd_wr same cycle; req0 drop -> gnt0=0, 2 gap cycles, IDLE.
REQ-034 req0=req1=1 after reset -> gnt0 first; after release with both still requesting -> gnt1 next; then gnt0.
REQ-035 gnt1 held, drive sd_byte_available/sd_dout=8'hA5 -> dout1=8'hA5, bavail1=1; writer sees rfnb0=0, ready0=0.
REQ-036 TIMEOUT_CYCLES=16, granted, sd_ready=0 for 16 cycles -> gnt drops at cycle 16, timeout_err=1, no re-grant until req cycled.
REQ-037 Reset asserted during GNT_W with wr0=1 -> next cycle gnt0=0, sd_wr=0, sd_address=0, state IDLE.
REQ-038 req1 arrives while sd_ready=0 in IDLE -> no grant until sd_ready=1, then gnt1 one cycle later.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and widths for the SD controller port arbiter.
package sd_pkg;

    localparam int SD_ADDR_W = 32;
    localparam int SD_DATA_W = 8;
    localparam int WD_CNT_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_W = 2'd1,
        GNT_R = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_WRITER = 1'b0,
        REQ_READER = 1'b1
    } req_id_t;

endpackage

// File: rtl/sd_watchdog.sv
// Stall watchdog: counts cycles while enabled, saturates at TIMEOUT_CYCLES-1
// and flags expiry while still counting at that limit.
module sd_watchdog
    import sd_pkg::*;
#(
    parameter logic [WD_CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic count,
    input  logic clear,
    output logic expire
);

    localparam logic [WD_CNT_W-1:0] LIMIT = TIMEOUT_CYCLES - 24'd1;

    logic [WD_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (count && (cnt != LIMIT)) begin
            cnt <= cnt + 24'd1;
        end
    end

    assign expire = count && (cnt == LIMIT);

endmodule

// File: rtl/sd_port_arbiter.sv
// Arbitrates one writer and one reader onto a single SD controller port,
// with round-robin tie-break, an inter-grant gap and a stall watchdog.
module sd_port_arbiter
    import sd_pkg::*;
#(
    parameter logic [WD_CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int                  GAP_CYCLES     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    output logic                 gnt0,
    input  logic                 wr0,
    input  logic [SD_ADDR_W-1:0] addr0,
    input  logic [SD_DATA_W-1:0] din0,
    output logic                 ready0,
    output logic                 rfnb0,
    input  logic                 req1,
    output logic                 gnt1,
    input  logic                 rd1,
    input  logic [SD_ADDR_W-1:0] addr1,
    output logic                 ready1,
    output logic [SD_DATA_W-1:0] dout1,
    output logic                 bavail1,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic [SD_ADDR_W-1:0] sd_address,
    output logic [SD_DATA_W-1:0] sd_din,
    input  logic                 sd_ready,
    input  logic [SD_DATA_W-1:0] sd_dout,
    input  logic                 sd_byte_available,
    input  logic                 sd_ready_for_next_byte,
    output logic                 timeout_err
);

    arb_state_t           state;
    req_id_t              rr_ptr;
    logic                 lock0;
    logic                 lock1;
    logic [7:0]           gap_cnt;
    logic [SD_ADDR_W-1:0] addr_q;
    logic                 wd_count;
    logic                 wd_expire;
    logic                 elig0;
    logic                 elig1;
    logic                 gap_done;

    assign wd_count = ((state == GNT_W) || (state == GNT_R)) && !sd_ready;
    assign elig0    = req0 && !lock0;
    assign elig1    = req1 && !lock1;
    assign gap_done = sd_ready && ((int'(gap_cnt) + 1) >= GAP_CYCLES);

    sd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .count (wd_count),
        .clear (!wd_count),
        .expire(wd_expire)
    );

    // Lockouts clear whenever the requester lets go; an abort re-arms them
    // so a stuck requester cannot immediately reclaim the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rr_ptr      <= REQ_WRITER;
            lock0       <= 1'b0;
            lock1       <= 1'b0;
            timeout_err <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            if (!req0) lock0 <= 1'b0;
            if (!req1) lock1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (sd_ready && elig0 && (!elig1 || rr_ptr == REQ_WRITER)) begin
                        state       <= GNT_W;
                        gnt0        <= 1'b1;
                        timeout_err <= 1'b0;
                    end else if (sd_ready && elig1) begin
                        state       <= GNT_R;
                        gnt1        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                GNT_W: begin
                    if (!req0 || wd_expire) begin
                        state   <= GAP;
                        gnt0    <= 1'b0;
                        rr_ptr  <= REQ_READER;
                        gap_cnt <= '0;
                        if (req0) begin
                            lock0       <= 1'b1;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                GNT_R: begin
                    if (!req1 || wd_expire) begin
                        state   <= GAP;
                        gnt1    <= 1'b0;
                        rr_ptr  <= REQ_WRITER;
                        gap_cnt <= '0;
                        if (req1) begin
                            lock1       <= 1'b1;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state <= IDLE;
                    end else if (gap_cnt != '1) begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The address bus keeps whatever the last owner drove once the grant ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else if (state == GNT_W) begin
            addr_q <= addr0;
        end else if (state == GNT_R) begin
            addr_q <= addr1;
        end
    end

    always_comb begin
        sd_rd      = 1'b0;
        sd_wr      = 1'b0;
        sd_address = addr_q;
        sd_din     = '0;
        ready0     = 1'b0;
        rfnb0      = 1'b0;
        ready1     = 1'b0;
        dout1      = '0;
        bavail1    = 1'b0;
        case (state)
            GNT_W: begin
                sd_wr      = wr0;
                sd_address = addr0;
                sd_din     = din0;
                ready0     = sd_ready;
                rfnb0      = sd_ready_for_next_byte;
            end
            GNT_R: begin
                sd_rd      = rd1;
                sd_address = addr1;
                ready1     = sd_ready;
                dout1      = sd_dout;
                bavail1    = sd_byte_available;
            end
            default: ;
        endcase
    end

endmodule
